pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on input and output. It is the next generation of the team's fixed 8-bit combinational adder benchmark. It generalises width, splits the carry chain into registered segments, and adds subtract mode, signed overflow and backpressure. It sits as a streaming arithmetic stage between a producer and a consumer that both use valid/ready.

## Interface
- WIDTH, 8: operand and sum width in bits; must be ≥ 2.
- STAGES, 2: number of carry segments, which equals the number of pipeline registers. WIDTH % STAGES == 0 is required; SEG = WIDTH/STAGES.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a, b, c, sub hold a valid operation.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- c  in  1  carry-in (borrow-in when sub=1).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  s, cout, ovf hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- s  out  WIDTH  sum or difference.
- cout  out  1  carry-out of bit WIDTH-1. In subtract mode this is the raw carry, so 1 means no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; cin' = sub ? ~c : c. Result: {cout, s} = a + B' + cin', computed modulo 2^(WIDTH+1).
  - Add: s = a + b + c.
  - Subtract: s = a − b − c.
- ovf = (a[W-1] == B'[W-1]) && (s[W-1] != a[W-1]).
- Stage k (0..STAGES-1) register contents:
  - valid bit v[k];
  - result bits s[(k+1)*SEG-1:0];
  - carry out of segment k;
  - upper operand slices a and B' above segment k;
  - a[W-1] and B'[W-1] for the overflow calculation.
- Stage 0 computes segment 0 from the inputs and cin'. Stage k>0 computes segment k from the stage k-1 registers, using that stage's stored carry.
- The last stage's register drives s, cout, ovf and out_valid (= v[STAGES-1]). No combinational path from a/b/c to s.
- Per-stage flow control with bubble collapse:
  - adv[STAGES-1] = v[STAGES-1] && out_ready.
  - Stage k accepts new data when free[k] = !v[k] || adv[k].
  - in_ready = free[0]. This is combinational from out_ready only through the free chain and has no dependence on in_valid.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Simultaneous input and output transfer in the same cycle is legal and sustains one op per cycle.
- Data registers load only on a transfer into the stage. When holding, all stage contents stay stable, including s/cout/ovf while out_valid=1 && out_ready=0.
- Order is strictly preserved; no op is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous) clears all v[k]=0 and s=0, cout=0, ovf=0, out_valid=0. in_ready is 1 during and after reset.
- Reset mid-operation discards all in-flight ops; no partial result appears after release.
- Latency: an op accepted at edge t gives out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles from acceptance to first presentation.
- Throughput is 1 op/cycle with out_ready held high.
- Full pipeline (all v=1, out_ready=0): in_ready=0. Raising out_ready makes in_ready=1 in the same cycle.
- Bubbles: an empty stage k is filled by stage k-1 even while the output is stalled.
- Capacity is exactly STAGES ops.

## Test plan
- Add, WIDTH=8, STAGES=2: a=0xFF, b=0x01, c=0, sub=0 -> after 2 cycles s=0x00, cout=1, ovf=0.
- Signed overflow add: a=0x7F, b=0x01, c=0 -> s=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> s=0x00, cout=1, ovf=1.
- Subtract: a=0x05, b=0x07, c=0, sub=1 -> s=0xFE, cout=0, ovf=0. Also a=0x80, b=0x01, sub=1 -> s=0x7F, cout=1, ovf=1. Also a=0x10, b=0x01, c=1, sub=1 -> s=0x0E, cout=1.
- Backpressure: stream 4 ops with out_ready=0 -> in_ready falls after 2 acceptances and the first result holds stable. Releasing out_ready delivers all 4 in order with no loss.
- Streaming: 1000 random ops each for WIDTH=8/STAGES=2, WIDTH=16/STAGES=4, WIDTH=32/STAGES=1, with random in_valid/out_ready -> every result matches the reference model, in order, and the output count equals the input count.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately, s=0, and no stale result after release.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Each pipeline stage resolves one SEG-bit carry segment.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] free;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] cy_n;
  word_t             a_q [STAGES];
  word_t             b_q [STAGES];
  word_t             s_q [STAGES];
  word_t             a_n [STAGES];
  word_t             b_n [STAGES];
  word_t             s_n [STAGES];

  // A stage is free when empty or when its occupant moves on this cycle;
  // the chain runs from out_ready backwards so bubbles collapse under stall.
  always_comb begin : flow
    logic down_free;
    down_free = out_ready;
    free      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free[k]   = !v[k] || down_free;
      down_free = free[k];
    end
  end

  always_comb begin : datapath
    logic [SEG:0] seg_sum;
    src_v    = '0;
    cy_n     = '0;
    src_v[0] = in_valid;
    a_n[0]   = a;
    b_n[0]   = sub ? ~b : b;
    s_n[0]   = '0;
    // cin' = sub ? ~c : c
    seg_sum  = {1'b0, a[SEG-1:0]} + {1'b0, b_n[0][SEG-1:0]} + {{SEG{1'b0}}, sub ^ c};
    s_n[0][SEG-1:0] = seg_sum[SEG-1:0];
    cy_n[0]  = seg_sum[SEG];
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v[k-1];
      a_n[k]   = a_q[k-1];
      b_n[k]   = b_q[k-1];
      s_n[k]   = s_q[k-1];
      seg_sum  = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
               + {{SEG{1'b0}}, cy_q[k-1]};
      s_n[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      cy_n[k]  = seg_sum[SEG];
    end
  end

  // Operand registers carry the full word; bits below the resolved segment
  // are never read and are trimmed by synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      cy_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (free[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]  <= a_n[k];
            b_q[k]  <= b_n[k];
            s_q[k]  <= s_n[k];
            cy_q[k] <= cy_n[k];
          end
        end
      end
    end
  end

  assign in_ready  = free[0];
  assign out_valid = v[LAST];
  assign s         = s_q[LAST];
  assign cout      = cy_q[LAST];
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
